// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTEXE   = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BEQ     = 4'd8,
    ST_ADDIEXE = 4'd9,
    ST_JUMP    = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // alu_op selects how the decoder derives alu_control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct to the ALU control code.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  // Fixed add/sub for address and branch math, funct-driven for R-type
  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control_fsm.sv
// Multicycle MIPS main control FSM.
//
// state   | meaning
// FETCH   | read instruction, PC += 4 when memory completes
// DECODE  | branch target into ALUOut, dispatch on opcode
// MEMADR  | compute lw/sw effective address
// MEMRD   | data read, wait for memory
// MEMWB   | load data into rt
// MEMWR   | data write, wait for memory
// RTEXE   | R-type ALU operation
// ALUWB   | ALU result into rd (R-type) or rt (addi)
// BEQ     | compare, conditionally load branch target
// ADDIEXE | rs + sign-extended immediate
// JUMP    | load jump target
module mips_mc_control_fsm
  import mips_mc_pkg::*;
#(
  parameter int STALL_EN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_e     state_q, state_d;
  logic       addi_q, addi_d;
  logic [1:0] alu_op;
  logic       funct_illegal;
  logic       rdy;

  assign rdy       = (STALL_EN != 0) ? mem_ready : 1'b1;
  assign state_dbg = state_q;

  mips_alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal)
  );

  // State and addi-path flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      addi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addi_q  <= addi_d;
    end
  end

  // Next state and Moore outputs; write strobes forced low during reset
  always_comb begin
    state_d       = state_q;
    addi_d        = addi_q;
    iord          = 1'b0;
    alu_src_a     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    alu_src_b     = SRCB_RD2;
    pc_src        = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMMSH2;
        addi_d    = (opcode == OP_ADDI);
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTEXE;
          OP_BEQ:       state_d = ST_BEQ;
          OP_ADDI:      state_d = ST_ADDIEXE;
          OP_J:         state_d = ST_JUMP;
          default: begin
            illegal_instr = 1'b1;
            state_d       = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (rdy) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (rdy) state_d = ST_FETCH;
      end
      ST_RTEXE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        if (funct_illegal) begin
          illegal_instr = 1'b1;
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_ALUWB;
        end
      end
      ST_ALUWB: begin
        reg_dst   = ~addi_q;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
        state_d   = ST_FETCH;
      end
      ST_ADDIEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ST_ALUWB;
      end
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    if (!reset_n) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Directed bench for the multicycle MIPS control FSM.
module tb_mips_mc_control_fsm;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       iord, alu_src_a, reg_dst, mem_to_reg, ir_write, mem_read;
  logic       mem_write, reg_write, pc_write, illegal_instr;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_mc_control_fsm #(.STALL_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .iord(iord), .alu_src_a(alu_src_a),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .pc_write(pc_write), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .illegal_instr(illegal_instr),
    .state_dbg(state_dbg)
  );

  task automatic test_reset();
    reset_n = 1'b0; opcode = OP_LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (state_dbg !== 4'(ST_FETCH)) begin n_bad++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_FETCH); end
    n_cmp++; if ({pc_write, ir_write, reg_write, mem_write, illegal_instr} !== 5'b0) begin n_bad++; $display("FAIL reset_gating got %b want 00000", {pc_write, ir_write, reg_write, mem_write, illegal_instr}); end
    n_cmp++; if (mem_read !== 1'b1 || alu_src_b !== SRCB_FOUR) begin n_bad++; $display("FAIL reset_fetch_ctl got rd=%b srcb=%b want rd=1 srcb=01", mem_read, alu_src_b); end
    @(posedge clk); #1;
    reset_n = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    state_e es[6] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_FETCH};
    opcode = OP_LW; funct = '0; zero = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c < 5);
      @(negedge clk);
      n_cmp++; if (state_dbg !== es[c]) begin n_bad++; $display("FAIL lw_state c%0d got %0d want %0d", c, state_dbg, es[c]); end
      n_cmp++; if (reg_write !== (c == 4)) begin n_bad++; $display("FAIL lw_reg_write c%0d got %b want %b", c, reg_write, (c == 4)); end
      if (c == 0) begin
        n_cmp++; if ({ir_write, pc_write, mem_read, iord, alu_control} !== {4'b1110, ALU_ADD}) begin n_bad++; $display("FAIL lw_fetch got %b want 1110010", {ir_write, pc_write, mem_read, iord, alu_control}); end
      end
      if (c == 1) begin
        n_cmp++; if (alu_src_b !== SRCB_IMMSH2 || alu_src_a !== 1'b0) begin n_bad++; $display("FAIL lw_decode srcb=%b srca=%b want 11/0", alu_src_b, alu_src_a); end
      end
      if (c == 3) begin
        n_cmp++; if ({iord, mem_read, mem_write} !== 3'b110) begin n_bad++; $display("FAIL lw_memrd got %b want 110", {iord, mem_read, mem_write}); end
      end
      if (c == 4) begin
        n_cmp++; if ({mem_to_reg, reg_dst} !== 2'b10) begin n_bad++; $display("FAIL lw_memwb got %b want 10", {mem_to_reg, reg_dst}); end
      end
      if (c == 5) begin
        n_cmp++; if (ir_write !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_irw got %b want 0", ir_write); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    state_e es[8] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR, ST_MEMWR, ST_MEMWR, ST_MEMWR, ST_FETCH};
    opcode = OP_SW; funct = '0; zero = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = !((c >= 3 && c <= 5) || c == 7);
      @(negedge clk);
      n_cmp++; if (state_dbg !== es[c]) begin n_bad++; $display("FAIL sw_state c%0d got %0d want %0d", c, state_dbg, es[c]); end
      n_cmp++; if (mem_write !== (c >= 3 && c <= 6)) begin n_bad++; $display("FAIL sw_mem_write c%0d got %b want %b", c, mem_write, (c >= 3 && c <= 6)); end
      if (c == 2) begin
        n_cmp++; if ({alu_src_a, alu_src_b} !== 3'b110) begin n_bad++; $display("FAIL sw_memadr got %b want 110", {alu_src_a, alu_src_b}); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq(input logic z);
    state_e es[4] = '{ST_FETCH, ST_DECODE, ST_BEQ, ST_FETCH};
    opcode = OP_BEQ; funct = '0; zero = z;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 0);
      @(negedge clk);
      n_cmp++; if (state_dbg !== es[c]) begin n_bad++; $display("FAIL beq_state z%b c%0d got %0d want %0d", z, c, state_dbg, es[c]); end
      if (c == 2) begin
        n_cmp++; if (pc_write !== z) begin n_bad++; $display("FAIL beq_pc_write z%b got %b want %b", z, pc_write, z); end
        n_cmp++; if (pc_src !== PCSRC_ALUOUT || alu_control !== ALU_SUB) begin n_bad++; $display("FAIL beq_ctl got src=%b alu=%b want 01/110", pc_src, alu_control); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] exp_alu, input logic legal);
    state_e es[5] = '{ST_FETCH, ST_DECODE, ST_RTEXE, ST_ALUWB, ST_FETCH};
    int n = legal ? 5 : 4;
    if (!legal) es[3] = ST_FETCH;
    opcode = OP_RTYPE; funct = fn; zero = 1'b0;
    for (int c = 0; c < n; c++) begin
      mem_ready = (c == 0);
      @(negedge clk);
      n_cmp++; if (state_dbg !== es[c]) begin n_bad++; $display("FAIL r_state fn%b c%0d got %0d want %0d", fn, c, state_dbg, es[c]); end
      n_cmp++; if (reg_write !== (legal && c == 3)) begin n_bad++; $display("FAIL r_reg_write fn%b c%0d got %b want %b", fn, c, reg_write, (legal && c == 3)); end
      if (c == 2) begin
        n_cmp++; if (illegal_instr !== !legal) begin n_bad++; $display("FAIL r_illegal fn%b got %b want %b", fn, illegal_instr, !legal); end
        if (legal) begin
          n_cmp++; if (alu_control !== exp_alu) begin n_bad++; $display("FAIL r_alu fn%b got %b want %b", fn, alu_control, exp_alu); end
        end
      end
      if (legal && c == 3) begin
        n_cmp++; if ({reg_dst, mem_to_reg} !== 2'b10) begin n_bad++; $display("FAIL r_aluwb got %b want 10", {reg_dst, mem_to_reg}); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    state_e es[5] = '{ST_FETCH, ST_DECODE, ST_ADDIEXE, ST_ALUWB, ST_FETCH};
    opcode = OP_ADDI; funct = FN_ADD; zero = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 0);
      @(negedge clk);
      n_cmp++; if (state_dbg !== es[c]) begin n_bad++; $display("FAIL addi_state c%0d got %0d want %0d", c, state_dbg, es[c]); end
      if (c == 2) begin
        n_cmp++; if ({alu_src_a, alu_src_b, alu_control} !== {3'b110, ALU_ADD}) begin n_bad++; $display("FAIL addi_exe got %b want 110010", {alu_src_a, alu_src_b, alu_control}); end
      end
      if (c == 3) begin
        n_cmp++; if ({reg_write, reg_dst} !== 2'b10) begin n_bad++; $display("FAIL addi_wb got %b want 10", {reg_write, reg_dst}); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_stall();
    state_e es[6] = '{ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_JUMP, ST_FETCH};
    opcode = OP_J; funct = '0; zero = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c == 2);
      @(negedge clk);
      n_cmp++; if (state_dbg !== es[c]) begin n_bad++; $display("FAIL j_state c%0d got %0d want %0d", c, state_dbg, es[c]); end
      n_cmp++; if (pc_write !== (c == 2 || c == 4)) begin n_bad++; $display("FAIL j_pc_write c%0d got %b want %b", c, pc_write, (c == 2 || c == 4)); end
      if (c == 4) begin
        n_cmp++; if (pc_src !== PCSRC_JUMP) begin n_bad++; $display("FAIL j_pc_src got %b want 10", pc_src); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_op();
    state_e es[3] = '{ST_FETCH, ST_DECODE, ST_FETCH};
    opcode = 6'b111111; funct = '0; zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c == 0);
      @(negedge clk);
      n_cmp++; if (state_dbg !== es[c]) begin n_bad++; $display("FAIL op_state c%0d got %0d want %0d", c, state_dbg, es[c]); end
      n_cmp++; if (illegal_instr !== (c == 1)) begin n_bad++; $display("FAIL op_illegal c%0d got %b want %b", c, illegal_instr, (c == 1)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    opcode = OP_LW; funct = '0; zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; mem_ready = 1'b0; end
    @(negedge clk);
    n_cmp++; if (state_dbg !== 4'(ST_MEMRD)) begin n_bad++; $display("FAIL mid_pre_state got %0d want %0d", state_dbg, ST_MEMRD); end
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (state_dbg !== 4'(ST_FETCH)) begin n_bad++; $display("FAIL mid_async_state got %0d want %0d", state_dbg, ST_FETCH); end
    n_cmp++; if ({reg_write, ir_write, pc_write} !== 3'b000) begin n_bad++; $display("FAIL mid_gating got %b want 000", {reg_write, ir_write, pc_write}); end
    @(posedge clk); #1;
    reset_n = 1'b1; opcode = OP_J;
    @(negedge clk);
    n_cmp++; if (state_dbg !== 4'(ST_FETCH) || reg_write !== 1'b0 || ir_write !== 1'b1) begin n_bad++; $display("FAIL mid_first_fetch got st=%0d rw=%b irw=%b want 0/0/1", state_dbg, reg_write, ir_write); end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (state_dbg !== 4'(ST_FETCH)) begin n_bad++; $display("FAIL mid_after_j got %0d want %0d", state_dbg, ST_FETCH); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_rtype(FN_SLT, ALU_SLT, 1'b1);
    test_rtype(FN_SUB, ALU_SUB, 1'b1);
    test_rtype(FN_OR,  ALU_OR,  1'b1);
    test_rtype(6'b111111, ALU_ADD, 1'b0);
    test_addi();
    test_rtype(FN_AND, ALU_AND, 1'b1);
    test_jump_stall();
    test_illegal_op();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_control_fsm.md
MIPS_MC_CONTROL_FSM -- requirements
Module: mips_mc_control_fsm

Interface
REQ-001 SHALL have parameter STALL_EN, default 1, meaning: 1 = honour mem_ready, 0 = treat mem_ready as constantly 1.
REQ-002 SHALL have ports: clk  in  1  system clock, rising-edge active; one clock, reset is asynchronous and active-low.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: opcode  in  6  instruction bits 31:26 from the instruction register.
REQ-005 SHALL have ports: funct  in  6  instruction bits 5:0.
REQ-006 SHALL have ports: zero  in  1  ALU zero flag.
REQ-007 SHALL have ports: mem_ready  in  1  unified memory completes the current access this cycle.
REQ-008 SHALL have ports: iord, alu_src_a, reg_dst, mem_to_reg, ir_write, mem_read, mem_write, reg_write  out  1  datapath controls.
REQ-009 SHALL have ports: pc_write  out  1  PC load enable, already combining the branch condition.
REQ-010 SHALL have ports: alu_src_b  out  2  (00 rd2, 01 const 4, 10 signimm, 11 signimm<<2); pc_src  out  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-011 SHALL have ports: alu_control  out  3  (010 add, 110 sub, 000 and, 001 or, 111 slt); illegal_instr  out  1  one-cycle flag; state_dbg  out  4  current state encoding.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, BEQ, ADDIEXE, JUMP.
REQ-013 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, add, pc_src=00; ir_write=pc_write=mem_ready; advance to DECODE only when mem_ready=1, otherwise hold.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next: lw/sw->MEMADR, R-type->RTEXE, beq->BEQ, addi->ADDIEXE, j->JUMP; any other opcode -> FETCH with illegal_instr=1 for that cycle.
REQ-015 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, add; next MEMRD (lw) or MEMWR (sw).
REQ-017 MEMRD: iord=1, mem_read=1; hold until mem_ready, then MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
REQ-018 MEMWR: iord=1, mem_write=1 held every cycle until mem_ready; mem_ready cycle -> FETCH.
REQ-019 RTEXE: alu_src_a=1, alu_src_b=00, alu_control from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); unknown funct -> illegal_instr=1, no ALUWB, next FETCH.
REQ-020 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-021 BEQ: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=zero -> FETCH.
REQ-022 ADDIEXE: alu_src_a=1, alu_src_b=10, add -> ALUWB with reg_dst forced 0 (an addi-path flag registered at DECODE).
REQ-023 JUMP: pc_src=10, pc_write=1 -> FETCH.
REQ-024 Outputs are Moore (from state plus mem_ready/zero gating only); all outputs not listed for a state are 0.
REQ-025 Latency in cycles with zero wait: lw 5, sw 4, R 4, addi 4, beq 3, j 3; each wait cycle adds exactly one.
REQ-026 mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Reset
REQ-027 reset_n=0 SHALL force state=FETCH asynchronously and gate pc_write, ir_write, reg_write, mem_write, illegal_instr to 0 while asserted.
REQ-028 Reset mid-instruction SHALL abandon it; first post-reset cycle is a FETCH with no writes from the abandoned instruction.

Structure
REQ-029 Shared package mips_mc_pkg SHALL hold state enum, opcode, funct and ALU-control constants.
REQ-030 Sub-module mips_alu_decoder SHALL map (alu_op 2-bit, funct) to alu_control plus funct_illegal; FSM owns everything else.

Verification
REQ-031 lw (op 100011), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 only in cycle 5, mem_to_reg=1.
REQ-032 sw with mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, back to FETCH on cycle 8.
REQ-033 beq with zero=1 -> pc_write=1, pc_src=01 in cycle 3; repeat with zero=0 -> pc_write=0.
REQ-034 R-type funct 101010 -> alu_control=111 in RTEXE; funct 111111 -> illegal_instr=1, no reg_write.
REQ-035 opcode 111111 -> illegal_instr pulse in DECODE, FETCH next; reset_n=0 during MEMRD -> state_dbg=FETCH immediately, no reg_write.
